// File: rtl/lii_pkg.sv
// ---------------------------------------------------------------------------
// lii_pkg
// Shared definitions for the LII egress path.
//   LII_ID_W   : width of the LII source/destination ids
//   LII_PW     : default packing width of a beat payload
//   lii_beat_t : one stored beat {src, dst, data} at the default width
//   lii_ptr_w  : pointer width for a power-of-two depth
//   lii_cnt_w  : occupancy counter width able to hold 0..depth
// ---------------------------------------------------------------------------
package lii_pkg;

  localparam int LII_ID_W = 8;
  localparam int LII_PW   = 64;

  typedef struct packed {
    logic [LII_ID_W-1:0] src;
    logic [LII_ID_W-1:0] dst;
    logic [LII_PW-1:0]   data;
  } lii_beat_t;

  // A depth of 1 would give a zero-width pointer, so keep at least one bit.
  function automatic int lii_ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int lii_cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/lii_fifo_ram.sv
// ---------------------------------------------------------------------------
// lii_fifo_ram
// Simple dual-port beat storage: synchronous write, asynchronous read.
// The read port feeds the head register of lii_egress_fifo directly.
// Ports:
//   clk_i    : write clock
//   we_i     : write enable
//   waddr_i  : write address
//   wdata_i  : write data ({src, dst, data})
//   raddr_i  : read address
//   rdata_o  : read data, combinational from raddr_i
// ---------------------------------------------------------------------------
module lii_fifo_ram
  import lii_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int W     = LII_PW + 2 * LII_ID_W,
  parameter int AW    = lii_ptr_w(DEPTH)
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [W-1:0]  rdata_o
);

  logic [W-1:0] mem_q [DEPTH];

  // Storage has no reset; validity is tracked by the occupancy count.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/lii_egress_fifo.sv
// ---------------------------------------------------------------------------
// lii_egress_fifo
// Elastic buffer between a stream wrapper's lii_out_p0 port and the LII
// fabric. Beats {src, dst, tdata} are stored in order and re-presented from a
// registered head, with occupancy and a programmable almost-full flag.
// Ports:
//   aclk, arst              : clock, synchronous active-high reset
//   s_tdata/s_src/s_dst     : upstream beat fields
//   s_tvalid / s_tready     : upstream handshake
//   m_tdata/m_src/m_dst     : head beat fields
//   m_tvalid / m_tready     : downstream handshake
//   count                   : occupancy including the head register
//   almost_full             : count >= AF_THRESH
// Optional (macro LII_EGRESS_STATS_EN):
//   pkt_cnt   : accepted output beats, wraps modulo 2^32
//   stall_cnt : cycles with m_tvalid & ~m_tready, wraps modulo 2^32
// ---------------------------------------------------------------------------
module lii_egress_fifo
  import lii_pkg::*;
#(
  parameter int PW        = 64,
  parameter int DEPTH     = 16,
  parameter int AF_THRESH = 12
) (
  input  logic                         aclk,
  input  logic                         arst,
  input  logic [PW-1:0]                s_tdata,
  input  logic                         s_tvalid,
  output logic                         s_tready,
  input  logic [LII_ID_W-1:0]          s_src,
  input  logic [LII_ID_W-1:0]          s_dst,
  output logic [PW-1:0]                m_tdata,
  output logic                         m_tvalid,
  input  logic                         m_tready,
  output logic [LII_ID_W-1:0]          m_src,
  output logic [LII_ID_W-1:0]          m_dst,
  output logic [lii_cnt_w(DEPTH)-1:0]  count,
  output logic                         almost_full
`ifdef LII_EGRESS_STATS_EN
  ,
  output logic [31:0]                  pkt_cnt,
  output logic [31:0]                  stall_cnt
`endif
);

  localparam int BW = PW + 2 * LII_ID_W;
  localparam int AW = lii_ptr_w(DEPTH);
  localparam int CW = lii_cnt_w(DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);

  logic [AW-1:0] wrPtr_q, wrPtr_d;
  logic [AW-1:0] rdPtr_q, rdPtr_d;
  logic [CW-1:0] count_q, count_d;
  logic          headValid_q, headValid_d;
  logic [BW-1:0] head_q, head_d;

  logic [BW-1:0] ramRdata;
  logic [BW-1:0] inBeat;
  logic          ramWe;
  logic          push;
  logic          pop;
  logic          headFree;
  logic          ramEmpty;
  logic [CW-1:0] ramCount;

  assign inBeat = {s_src, s_dst, s_tdata};

  // Ready depends only on registered count, never on m_tready.
  assign s_tready    = (count_q < DEPTH_C) & ~arst;
  assign almost_full = (count_q >= AF_C);
  assign count       = count_q;
  assign m_tvalid    = headValid_q;
  assign {m_src, m_dst, m_tdata} = head_q;

  lii_fifo_ram #(
    .DEPTH (DEPTH),
    .W     (BW),
    .AW    (AW)
  ) u_ram (
    .clk_i   (aclk),
    .we_i    (ramWe),
    .waddr_i (wrPtr_q),
    .wdata_i (inBeat),
    .raddr_i (rdPtr_q),
    .rdata_o (ramRdata)
  );

  // The head is reloaded whenever it is empty or being popped. The RAM
  // always holds the older beats, so it wins over an incoming beat; the
  // incoming beat bypasses straight into the head only when the RAM is empty.
  always_comb begin
    push        = s_tvalid & s_tready;
    pop         = headValid_q & m_tready;
    ramCount    = count_q - CW'(headValid_q);
    ramEmpty    = (ramCount == '0);
    headFree    = ~headValid_q | pop;
    head_d      = head_q;
    headValid_d = headValid_q;
    rdPtr_d     = rdPtr_q;
    wrPtr_d     = wrPtr_q;
    ramWe       = 1'b0;

    if (headFree) begin
      if (!ramEmpty) begin
        head_d      = ramRdata;
        headValid_d = 1'b1;
        rdPtr_d     = rdPtr_q + AW'(1);
      end else if (push) begin
        head_d      = inBeat;
        headValid_d = 1'b1;
      end else begin
        headValid_d = 1'b0;
      end
    end

    if (push && !(headFree && ramEmpty)) begin
      ramWe   = 1'b1;
      wrPtr_d = wrPtr_q + AW'(1);
    end

    count_d = count_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge aclk) begin
    if (arst) begin
      wrPtr_q     <= '0;
      rdPtr_q     <= '0;
      count_q     <= '0;
      headValid_q <= 1'b0;
      head_q      <= '0;
    end else begin
      wrPtr_q     <= wrPtr_d;
      rdPtr_q     <= rdPtr_d;
      count_q     <= count_d;
      headValid_q <= headValid_d;
      head_q      <= head_d;
    end
  end

`ifdef LII_EGRESS_STATS_EN
  logic [31:0] pktCnt_q;
  logic [31:0] stallCnt_q;

  always_ff @(posedge aclk) begin
    if (arst) begin
      pktCnt_q   <= '0;
      stallCnt_q <= '0;
    end else begin
      if (pop) begin
        pktCnt_q <= pktCnt_q + 32'd1;
      end
      if (headValid_q && !m_tready) begin
        stallCnt_q <= stallCnt_q + 32'd1;
      end
    end
  end

  assign pkt_cnt   = pktCnt_q;
  assign stall_cnt = stallCnt_q;
`endif

endmodule

// File: tb/tb_lii_egress_fifo.sv
// ---------------------------------------------------------------------------
// tb_lii_egress_fifo
// Self-checking bench for lii_egress_fifo. A queue-based reference model
// advances on each rising edge from the driven inputs; a monitor on the
// falling edge compares every DUT output against it.
// ---------------------------------------------------------------------------
module tb_lii_egress_fifo;
  import lii_pkg::*;

  localparam int PW    = 64;
  localparam int DEPTH = 16;
  localparam int AF    = 12;

  logic          clk = 1'b0;
  logic          arst = 1'b1;
  logic [PW-1:0] sTdata = '0;
  logic          sTvalid = 1'b0;
  logic          sTready;
  logic [7:0]    sSrc = '0;
  logic [7:0]    sDst = '0;
  logic [PW-1:0] mTdata;
  logic          mTvalid;
  logic          mTready = 1'b0;
  logic [7:0]    mSrc;
  logic [7:0]    mDst;
  logic [4:0]    count;
  logic          almostFull;
`ifdef LII_EGRESS_STATS_EN
  logic [31:0]   pktCnt;
  logic [31:0]   stallCnt;
  int unsigned   modelPkt = 0;
  int unsigned   modelStall = 0;
`endif

  lii_beat_t expQ[$];
  int        compared = 0;
  int        mismatched = 0;
  bit        checkEn = 1'b0;

  always #5 clk = ~clk;

  lii_egress_fifo #(.PW(PW), .DEPTH(DEPTH), .AF_THRESH(AF)) dut (
    .aclk        (clk),
    .arst        (arst),
    .s_tdata     (sTdata),
    .s_tvalid    (sTvalid),
    .s_tready    (sTready),
    .s_src       (sSrc),
    .s_dst       (sDst),
    .m_tdata     (mTdata),
    .m_tvalid    (mTvalid),
    .m_tready    (mTready),
    .m_src       (mSrc),
    .m_dst       (mDst),
    .count       (count),
    .almost_full (almostFull)
`ifdef LII_EGRESS_STATS_EN
    ,
    .pkt_cnt     (pktCnt),
    .stall_cnt   (stallCnt)
`endif
  );

  // Reference model: a plain FIFO of beats with capacity DEPTH. A pop is
  // decided from the occupancy before the edge, as is acceptance of a push.
  always @(posedge clk) begin
    int sz;
    bit doPop;
    bit doPush;
    sz = expQ.size();
    if (arst) begin
      expQ.delete();
`ifdef LII_EGRESS_STATS_EN
      modelPkt   = 0;
      modelStall = 0;
`endif
    end else begin
      doPop  = (sz > 0) && mTready;
      doPush = sTvalid && (sz < DEPTH);
`ifdef LII_EGRESS_STATS_EN
      if (doPop) modelPkt = modelPkt + 1;
      if ((sz > 0) && !mTready) modelStall = modelStall + 1;
`endif
      if (doPop) void'(expQ.pop_front());
      if (doPush) expQ.push_back('{src: sSrc, dst: sDst, data: sTdata});
    end
  end

  task automatic checkOutput(input string name, input logic [79:0] actual,
                             input logic [79:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  // Monitor: compares status every cycle and the head beat whenever the
  // model holds one (covers both hold-while-stalled and accepted beats).
  always @(negedge clk) begin
    int sz;
    if (checkEn) begin
      sz = expQ.size();
      checkOutput("count", 80'(count), 80'(sz));
      checkOutput("m_tvalid", 80'(mTvalid), 80'(sz > 0));
      checkOutput("s_tready", 80'(sTready), 80'((sz < DEPTH) && !arst));
      checkOutput("almost_full", 80'(almostFull), 80'(sz >= AF));
      if (sz > 0) begin
        checkOutput("head_beat", {mSrc, mDst, mTdata}, expQ[0]);
      end
`ifdef LII_EGRESS_STATS_EN
      checkOutput("pkt_cnt", 80'(pktCnt), 80'(modelPkt));
      checkOutput("stall_cnt", 80'(stallCnt), 80'(modelStall));
`endif
    end
  end

  // Drive one cycle of inputs, then advance past the next rising edge.
  task automatic applyStimulus(input logic rst, input logic valid,
                               input logic [PW-1:0] data, input logic [7:0] src,
                               input logic [7:0] dst, input logic ready);
    arst    = rst;
    sTvalid = valid;
    sTdata  = data;
    sSrc    = src;
    sDst    = dst;
    mTready = ready;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset held for three cycles with a pending upstream beat.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b1, 64'hDEAD, 8'h11, 8'h22, 1'b0);
      checkEn = 1'b1;
    end

    // Idle cycle after reset: ready must be back.
    applyStimulus(1'b0, 1'b0, '0, '0, '0, 1'b0);

    // Single beat, then hold it stalled for ten cycles.
    applyStimulus(1'b0, 1'b1, 64'h0123_4567_89AB_CDEF, 8'h02, 8'h05, 1'b0);
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b0, '0, '0, '0, 1'b0);
    applyStimulus(1'b0, 1'b0, '0, '0, '0, 1'b1);

    // Fill to DEPTH with values 0..15, attempt a 17th push, then drain.
    for (int i = 0; i < DEPTH; i++)
      applyStimulus(1'b0, 1'b1, 64'(i), 8'(i), 8'(i + 100), 1'b0);
    applyStimulus(1'b0, 1'b1, 64'hBAD, 8'hEE, 8'hEE, 1'b0);
    for (int i = 0; i < DEPTH + 1; i++) applyStimulus(1'b0, 1'b0, '0, '0, '0, 1'b1);

    // Continuous streaming, 100 beats with incrementing data.
    for (int i = 0; i < 100; i++)
      applyStimulus(1'b0, 1'b1, 64'(1000 + i), 8'(i), 8'(255 - i), 1'b1);
    applyStimulus(1'b0, 1'b0, '0, '0, '0, 1'b1);

    // Full with simultaneous pop and push, then push accepted next cycle.
    for (int i = 0; i < DEPTH; i++)
      applyStimulus(1'b0, 1'b1, 64'(500 + i), 8'h33, 8'h44, 1'b0);
    applyStimulus(1'b0, 1'b1, 64'h777, 8'h77, 8'h77, 1'b1);
    applyStimulus(1'b0, 1'b1, 64'h778, 8'h78, 8'h78, 1'b1);
    for (int i = 0; i < DEPTH + 1; i++) applyStimulus(1'b0, 1'b0, '0, '0, '0, 1'b1);

    // Mid-operation reset at count 7; the next beat must be first out.
    for (int i = 0; i < 7; i++)
      applyStimulus(1'b0, 1'b1, 64'(900 + i), 8'h55, 8'h66, 1'b0);
    applyStimulus(1'b1, 1'b0, '0, '0, '0, 1'b0);
    applyStimulus(1'b0, 1'b1, 64'hFACE, 8'h0A, 8'h0B, 1'b0);
    applyStimulus(1'b0, 1'b0, '0, '0, '0, 1'b1);
    applyStimulus(1'b0, 1'b0, '0, '0, '0, 1'b1);

    // Random traffic with phases of varying pressure, including rare resets.
    for (int phase = 0; phase < 4; phase++) begin
      for (int i = 0; i < 500; i++) begin
        logic v;
        logic r;
        logic rs;
        v  = ($urandom_range(0, 3) < 3 - (phase == 3 ? 2 : 0));
        r  = ($urandom_range(0, 3) < (phase == 1 ? 1 : 2 + (phase == 3 ? 1 : 0)));
        rs = ($urandom_range(0, 299) == 0);
        applyStimulus(rs, v, {$urandom, $urandom}, 8'($urandom), 8'($urandom), r);
      end
    end

    // Drain and finish.
    for (int i = 0; i < DEPTH + 2; i++) applyStimulus(1'b0, 1'b0, '0, '0, '0, 1'b1);
    checkEn = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
